// File: rtl/tt_sweep_pkg.sv
// Shared types and helpers for the truth-table sweeper: FSM states, row/code types,
// and the row-to-code-bit mapping (row 000 lands in the MSB).
package tt_sweep_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_e;

  typedef logic [2:0] row_t;
  typedef logic [7:0] tt_code_t;

  localparam int unsigned NUM_ROWS = 8;

  function automatic row_t row_bit(row_t r);
    return row_t'(3'd7 - r);
  endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Per-row settle counter: counts cycles while enabled and flags the last settle cycle.
module tt_settle_timer #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign expire = en && (r_cnt == CNT_W'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps a 3-input gate through all 8 rows, captures its truth-table code and compares it
// to a latched expected code. Define TRUTH_TABLE_SWEEPER_ERRLOG_EN for per-row error logging.
module truth_table_sweeper
  import tt_sweep_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] expected,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] observed,
  output logic       drv_in1,
  output logic       drv_in2,
  output logic       drv_in3,
  input  logic       dut_out
`ifdef TRUTH_TABLE_SWEEPER_ERRLOG_EN
  ,
  output logic [3:0] err_count,
  output logic [2:0] first_err_row
`endif
);

  state_e   r_state;
  row_t     r_row;
  tt_code_t r_observed;
  tt_code_t r_expected;
  logic     r_busy;
  logic     r_done;
  logic     r_pass;

  logic     w_accept;
  logic     w_expire;
  row_t     w_bit;
  tt_code_t w_obs_next;

  assign w_accept = (r_state == IDLE) && start;
  assign w_bit    = row_bit(r_row);

  // Final compare must include the row-7 bit being captured this cycle.
  always_comb begin
    w_obs_next        = r_observed;
    w_obs_next[w_bit] = dut_out;
  end

  tt_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_accept || (r_state == SAMPLE)),
    .en    (r_state == SETTLE),
    .expire(w_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_row      <= '0;
      r_observed <= '0;
      r_expected <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_expected <= expected;
            r_observed <= '0;
            r_row      <= '0;
            r_pass     <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= SETTLE;
          end
        end
        SETTLE: begin
          if (w_expire) r_state <= SAMPLE;
        end
        SAMPLE: begin
          r_observed <= w_obs_next;
          if (r_row == row_t'(NUM_ROWS - 1)) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_obs_next == r_expected);
            r_state <= DONE;
          end else begin
            r_row   <= r_row + 3'd1;
            r_state <= SETTLE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign pass     = r_pass;
  assign observed = r_observed;
  assign {drv_in1, drv_in2, drv_in3} = r_row;

`ifdef TRUTH_TABLE_SWEEPER_ERRLOG_EN
  logic [3:0] r_err_count;
  row_t       r_first_err_row;

  always_ff @(posedge clk) begin
    if (rst || w_accept) begin
      r_err_count     <= '0;
      r_first_err_row <= '0;
    end else if ((r_state == SAMPLE) && (dut_out != r_expected[w_bit])) begin
      r_err_count <= r_err_count + 4'd1;
      if (r_err_count == 4'd0) r_first_err_row <= r_row;
    end
  end

  assign err_count     = r_err_count;
  assign first_err_row = r_first_err_row;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: vector table of sweeps plus hand-written
// reset/restart/start-hold sequences and a SETTLE_CYCLES=1 instance.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, start1;
  logic [7:0] expected, expected1;
  logic       busy, done, pass, busy1, done1, pass1;
  logic [7:0] observed, observed1;
  logic       drv_in1, drv_in2, drv_in3, drv1_in1, drv1_in2, drv1_in3;
  logic       dut_out, dut_out1;
  logic [1:0] mode;
  logic [2:0] row_obs, row_obs1;
`ifdef TRUTH_TABLE_SWEEPER_ERRLOG_EN
  logic [3:0] err_count, err_count1;
  logic [2:0] first_err_row, first_err_row1;
`endif

  assign row_obs  = {drv_in1, drv_in2, drv_in3};
  assign row_obs1 = {drv1_in1, drv1_in2, drv1_in3};

  // Gate models: 0 = 0xEE reference gate, 1 = tied low, 2 = tied high.
  always_comb begin
    dut_out = 1'b1;
    case (mode)
      2'd0:    dut_out = ~(drv_in2 & drv_in3);
      2'd1:    dut_out = 1'b0;
      default: dut_out = 1'b1;
    endcase
  end
  assign dut_out1 = ~(drv1_in2 & drv1_in3);

  truth_table_sweeper #(.SETTLE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .expected(expected),
    .busy(busy), .done(done), .pass(pass), .observed(observed),
    .drv_in1(drv_in1), .drv_in2(drv_in2), .drv_in3(drv_in3), .dut_out(dut_out)
`ifdef TRUTH_TABLE_SWEEPER_ERRLOG_EN
    , .err_count(err_count), .first_err_row(first_err_row)
`endif
  );

  truth_table_sweeper #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .expected(expected1),
    .busy(busy1), .done(done1), .pass(pass1), .observed(observed1),
    .drv_in1(drv1_in1), .drv_in2(drv1_in2), .drv_in3(drv1_in3), .dut_out(dut_out1)
`ifdef TRUTH_TABLE_SWEEPER_ERRLOG_EN
    , .err_count(err_count1), .first_err_row(first_err_row1)
`endif
  );

  typedef struct {
    logic [1:0] mode;
    logic [7:0] exp_code;
    int         pulse_a;
    int         pulse_b;
    logic [7:0] want_obs;
    logic       want_pass;
    logic [3:0] want_errs;
    logic [2:0] want_first;
  } vec_t;

  vec_t vecs[6];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, got, want);
    end
  endtask

  task automatic run_sweep(input vec_t v);
    int hold[8];
    int cyc;
    logic order_ok;
    logic [2:0] prev;
    logic [7:0] obs_final;
    for (int i = 0; i < 8; i++) hold[i] = 0;
    mode     = v.mode;
    expected = v.exp_code;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_rise", busy, 1);
    chk("obs_clear", observed, 0);
    cyc = 1;
    prev = 3'd0;
    order_ok = 1'b1;
    while (done !== 1'b1 && cyc < 200) begin
      if (busy === 1'b1) begin
        hold[row_obs]++;
        if (row_obs < prev) order_ok = 1'b0;
        prev = row_obs;
      end
      if (cyc == v.pulse_a || cyc == v.pulse_b) begin
        start    = 1'b1;
        expected = 8'h00;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk("done_cycle", cyc, 41);
    chk("busy_in_done", busy, 0);
    chk("observed", observed, v.want_obs);
    chk("pass", pass, v.want_pass);
`ifdef TRUTH_TABLE_SWEEPER_ERRLOG_EN
    chk("err_count", err_count, v.want_errs);
    chk("first_err_row", first_err_row, v.want_first);
`endif
    chk("row_order", order_ok, 1);
    for (int i = 0; i < 8; i++) chk($sformatf("row%0d_hold", i), hold[i], 5);
    obs_final = observed;
    @(posedge clk); #1;
    chk("done_single", done, 0);
    chk("drv_hold_111", row_obs, 3'b111);
    chk("obs_hold", observed, obs_final);
    chk("pass_hold", pass, v.want_pass);
  endtask

  initial begin
    int cyc;
    int hold1[8];
    logic seen;

    vecs[0] = '{2'd0, 8'hEE, 0, 0,  8'hEE, 1'b1, 4'd0, 3'd0};
    vecs[1] = '{2'd0, 8'hEF, 0, 0,  8'hEE, 1'b0, 4'd1, 3'd7};
    vecs[2] = '{2'd1, 8'h00, 0, 0,  8'h00, 1'b1, 4'd0, 3'd0};
    vecs[3] = '{2'd2, 8'h00, 0, 0,  8'hFF, 1'b0, 4'd8, 3'd0};
    vecs[4] = '{2'd0, 8'h00, 0, 0,  8'hEE, 1'b0, 4'd6, 3'd0};
    vecs[5] = '{2'd0, 8'hEE, 3, 20, 8'hEE, 1'b1, 4'd0, 3'd0};

    rst = 1'b1; start = 1'b0; start1 = 1'b0;
    expected = 8'h00; expected1 = 8'hEE; mode = 2'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_observed", observed, 0);
    chk("rst_drv", row_obs, 0);
    chk("rst_busy1", busy1, 0);

    for (int i = 0; i < 6; i++) run_sweep(vecs[i]);

    // Reset in the middle of a sweep.
    mode = 2'd0; expected = 8'hEE; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (cyc < 17) begin
      @(posedge clk); #1;
      cyc++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_observed", observed, 0);
    chk("midrst_drv", row_obs, 0);
    chk("midrst_done", done, 0);
    seen = 1'b0;
    repeat (50) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen = 1'b1;
    end
    chk("midrst_no_done", seen, 0);
    run_sweep(vecs[0]);

    // Start held high: ignored mid-sweep and in DONE, restarts in the next IDLE cycle.
    mode = 2'd0; expected = 8'hEE; start = 1'b1;
    @(posedge clk); #1;
    cyc = 1;
    while (done !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("hold_done_cycle", cyc, 41);
    chk("hold_pass", pass, 1);
    @(posedge clk); #1;
    chk("hold_idle_busy", busy, 0);
    chk("hold_idle_done", done, 0);
    @(posedge clk); #1;
    chk("hold_restart_busy", busy, 1);
    chk("hold_restart_obs", observed, 0);
    start = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    // SETTLE_CYCLES=1 instance.
    for (int i = 0; i < 8; i++) hold1[i] = 0;
    expected1 = 8'hEE; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    cyc = 1;
    while (done1 !== 1'b1 && cyc < 200) begin
      if (busy1 === 1'b1) hold1[row_obs1]++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("s1_done_cycle", cyc, 17);
    chk("s1_observed", observed1, 8'hEE);
    chk("s1_pass", pass1, 1);
    for (int i = 0; i < 8; i++) chk($sformatf("s1_row%0d_hold", i), hold1[i], 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Upstream stimulus and capture stage for a 3-input combinational logic gate block in the truth-table library, e.g. the 0xEE NAND-like function.
- On start, drives in1/in2/in3 through all 8 rows, waits a settle interval per row, and samples the gate's out.
- Assembles the observed 8-bit truth-table code and compares it against an expected code.
- Used to characterise and regression-check gate netlists in simulation and on FPGA.

Parameters:
- SETTLE_CYCLES, 4: cycles each row is held before sampling; legal range 1..255.
- CNT_W, $clog2(SETTLE_CYCLES+1): settle counter width; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a sweep; sampled only in IDLE
- expected  input  8  expected truth-table code; latched when start is accepted
- busy  output  1  high while a sweep is in progress
- done  output  1  single-cycle pulse when the sweep completes
- pass  output  1  observed == expected latched code; valid from done until the next accepted start
- observed  output  8  captured truth-table code
- drv_in1  output  1  stimulus to gate in1 (row bit 2)
- drv_in2  output  1  stimulus to gate in2 (row bit 1)
- drv_in3  output  1  stimulus to gate in3 (row bit 0)
- dut_out  input  1  gate output under test

Behaviour:
- Row index: r = {drv_in1,drv_in2,drv_in3}, 0..7, swept in ascending order.
- Code convention: the output for row r is stored in bit (7-r), so row 000 is the MSB.
  - Example: rows 000..111 giving 1,1,1,0,1,1,1,0 produce code 0xEE.
- Reset values: busy=0, done=0, pass=0, observed=0x00, drv_in*=0, row=0, counter=0, state=IDLE.
- IDLE:
  - If start=1, latch expected, clear observed to 0x00, set row=0 and counter=0, go to SETTLE.
  - busy rises in the cycle after the start edge.
- SETTLE:
  - drv_in* = row.
  - Counter increments each cycle.
  - When counter == SETTLE_CYCLES-1, go to SAMPLE.
- SAMPLE (1 cycle), drv_in* still = row:
  - observed[7-row] <= dut_out; reset counter.
  - If row==7, go to DONE; else row <= row+1 and go to SETTLE.
- DONE (1 cycle):
  - done=1; pass <= (observed == latched expected), computed from the final observed value including row 7.
  - busy=0 in this cycle; go to IDLE.
- Latency: done is asserted exactly 8*(SETTLE_CYCLES+1)+1 cycles after the start-accept edge; 41 cycles at the default.
- Stimulus timing: drv_in* change only on the SAMPLE→SETTLE transition. Each row is stable for SETTLE_CYCLES+1 cycles.
- Post-sweep hold: after DONE, drv_in* stay at 3'b111 and observed/pass hold until the next accepted start.
- Boundary conditions:
  - start while busy is ignored; expected is not re-latched.
  - start high in the DONE cycle is ignored.
  - A start held continuously restarts a sweep on the first IDLE cycle after DONE.
  - rst mid-sweep: next cycle returns to reset values; no done pulse; partial observed is discarded.
  - SETTLE_CYCLES=1: SETTLE lasts one cycle per row.
  - X/Z on dut_out is captured as-is and not filtered.

Optional Feature:
- Macro: TRUTH_TABLE_SWEEPER_ERRLOG_EN.
- Defined:
  - Adds outputs err_count (4 bits, 0..8) and first_err_row (3 bits).
  - In each SAMPLE cycle where dut_out != latched expected[7-row], err_count increments. first_err_row records the row of the first mismatch.
  - Both clear on start accept and reset. first_err_row = 0 when err_count = 0.
  - Both are final by the done cycle.
- Undefined:
  - Ports are absent, no logic is generated, and pass behaviour is unchanged.

Decomposition:
- Package tt_sweep_pkg:
  - state enum {IDLE, SETTLE, SAMPLE, DONE}
  - typedef row_t (3-bit) and tt_code_t (8-bit)
  - constant NUM_ROWS=8
  - function row_bit(row_t r) returning 7-r
- Sub-module tt_settle_timer (parameter SETTLE_CYCLES):
  - Inputs clk, rst, clr, en; output expire.
  - Asserted on the last settle cycle.
- Top level holds the FSM, row register, and capture register.

Test Plan:
- Reference 0xEE gate (out = ~(in2&in3)), expected=0xEE, start pulse → done at cycle 41 post-accept, observed=0xEE, pass=1, drv_in* stepped 000..111 each held 5 cycles.
- Same gate, expected=0xEF → observed=0xEE, pass=0. With ERRLOG: err_count=1, first_err_row=7.
- dut_out tied 0, expected=0x00 → pass=1. dut_out tied 1, expected=0x00 → observed=0xFF, pass=0, err_count=8, first_err_row=0.
- start re-pulsed at cycles 3 and 20 of a sweep, expected changed to 0x00 at those pulses → ignored; a single done at cycle 41, compared against the original 0xEE.
- rst asserted at cycle 17 of a sweep → next cycle busy=0, observed=0x00, drv_in*=000, no done. A new start then completes normally with pass=1.
- SETTLE_CYCLES=1 build, 0xEE gate → done at cycle 17, observed=0xEE, each row held 2 cycles.
